srat_ckpt: RTL and testbench

SRAT_CKPT -- requirements
Module: srat_ckpt

---
 rtl/rename_pkg.sv | 10 +
 rtl/srat_ckpt_if.sv | 36 +++
 rtl/ckpt_ptr_ctrl.sv | 63 ++++++
 rtl/srat_ckpt.sv | 78 +++++++
 tb/tb_srat_ckpt.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Shared constants and types for the speculative rename table with checkpoints.
package rename_pkg;
  localparam int ARCH_NUM     = 32;
  localparam int ARCH_W       = 5;
  localparam int PHY_W_DEF    = 7;
  localparam int CKPT_NUM_DEF = 4;
  localparam int CKPT_W_DEF   = $clog2(CKPT_NUM_DEF);

  typedef logic [CKPT_W_DEF-1:0] ckpt_id_t;
endpackage

// File: rtl/srat_ckpt_if.sv
// Rename table bus: lookup channel, write channel and checkpoint control.
interface sRAT_if
  import rename_pkg::*;
#(
  parameter int RD_PORTS = 4,
  parameter int WR_PORTS = 2,
  parameter int PHY_W    = PHY_W_DEF,
  parameter int CKPT_NUM = CKPT_NUM_DEF
);
  localparam int CW = $clog2(CKPT_NUM);

  logic [RD_PORTS-1:0][ARCH_W-1:0] rd_arch;
  logic [RD_PORTS-1:0][PHY_W-1:0]  rd_phy;
  logic [WR_PORTS-1:0]             wr_en;
  logic [WR_PORTS-1:0][ARCH_W-1:0] wr_arch;
  logic [WR_PORTS-1:0][PHY_W-1:0]  wr_phy;
  logic                            ckpt_req;
  logic                            ckpt_ready;
  logic [CW-1:0]                   ckpt_id;
  logic                            ckpt_release;
  logic                            recover_valid;
  logic [CW-1:0]                   recover_id;
  logic [CW:0]                     ckpt_cnt;

  modport master (
    output rd_arch, wr_en, wr_arch, wr_phy, ckpt_req, ckpt_release,
           recover_valid, recover_id,
    input  rd_phy, ckpt_ready, ckpt_id, ckpt_cnt
  );

  modport slave (
    input  rd_arch, wr_en, wr_arch, wr_phy, ckpt_req, ckpt_release,
           recover_valid, recover_id,
    output rd_phy, ckpt_ready, ckpt_id, ckpt_cnt
  );
endinterface

// File: rtl/ckpt_ptr_ctrl.sv
// Checkpoint ring bookkeeping: head/tail with wrap bit, slot valid bits, count.
module ckpt_ptr_ctrl
  import rename_pkg::*;
#(
  parameter int CKPT_NUM = CKPT_NUM_DEF,
  localparam int CW      = $clog2(CKPT_NUM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ckpt_req,
  input  logic          ckpt_release,
  input  logic          recover_valid,
  input  logic [CW-1:0] recover_id,
  output logic          ckpt_ready,
  output logic [CW-1:0] ckpt_id,
  output logic [CW:0]   ckpt_cnt,
  output logic          snap_en,
  output logic          rec_en
);
  logic [CW:0]         head_q, tail_q;
  logic [CKPT_NUM-1:0] valid_q;
  logic [CKPT_NUM-1:0] keep_mask;
  logic [CW-1:0]       rec_dist;
  logic                rel_en;

  assign ckpt_cnt   = tail_q - head_q;
  assign ckpt_ready = ckpt_cnt < (CW+1)'(CKPT_NUM);
  assign ckpt_id    = tail_q[CW-1:0];
  assign rec_en     = recover_valid & valid_q[recover_id];
  assign snap_en    = ckpt_req & ckpt_ready & ~rec_en;
  assign rel_en     = ckpt_release & (ckpt_cnt != '0) & ~rec_en;
  assign rec_dist   = recover_id - head_q[CW-1:0];

  // On recover, keep only slots older than the restored one (distance from head).
  always_comb begin
    keep_mask = '0;
    for (int unsigned j = 0; j < CKPT_NUM; j++) begin
      keep_mask[j] = (CW'(j) - head_q[CW-1:0]) < rec_dist;
    end
  end

  // Pointer, valid-bit and count state; recover takes priority over alloc/release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else if (rec_en) begin
      // recover_id lies between head and tail, so head + distance restores the wrap bit
      tail_q  <= head_q + {1'b0, rec_dist};
      valid_q <= valid_q & keep_mask;
    end else begin
      if (snap_en) begin
        valid_q[tail_q[CW-1:0]] <= 1'b1;
        tail_q                  <= tail_q + 1'b1;
      end
      if (rel_en) begin
        valid_q[head_q[CW-1:0]] <= 1'b0;
        head_q                  <= head_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/srat_ckpt.sv
// Speculative register alias table with a ring of full-table checkpoints.
module srat_ckpt
  import rename_pkg::*;
#(
  parameter int RD_PORTS = 4,
  parameter int WR_PORTS = 2,
  parameter int PHY_W    = PHY_W_DEF,
  parameter int CKPT_NUM = CKPT_NUM_DEF
) (
  input logic   clk,
  input logic   rst_n,
  sRAT_if.slave bus
);
  logic [PHY_W-1:0] table_q    [ARCH_NUM];
  logic [PHY_W-1:0] table_next [ARCH_NUM];
  logic [PHY_W-1:0] snap_q     [CKPT_NUM][ARCH_NUM];
  logic             snap_en;
  logic             rec_en;

  ckpt_ptr_ctrl #(.CKPT_NUM(CKPT_NUM)) u_ptr (
    .clk          (clk),
    .rst_n        (rst_n),
    .ckpt_req     (bus.ckpt_req),
    .ckpt_release (bus.ckpt_release),
    .recover_valid(bus.recover_valid),
    .recover_id   (bus.recover_id),
    .ckpt_ready   (bus.ckpt_ready),
    .ckpt_id      (bus.ckpt_id),
    .ckpt_cnt     (bus.ckpt_cnt),
    .snap_en      (snap_en),
    .rec_en       (rec_en)
  );

  // Lookups read the registered table only; same-cycle writes are not bypassed.
  always_comb begin
    for (int unsigned i = 0; i < RD_PORTS; i++) begin
      bus.rd_phy[i] = table_q[bus.rd_arch[i]];
    end
  end

  // Next table: recovered snapshot, or writes applied low-to-high so the top port wins.
  always_comb begin
    table_next = table_q;
    if (rec_en) begin
      table_next = snap_q[bus.recover_id];
    end else begin
      for (int unsigned p = 0; p < WR_PORTS; p++) begin
        if (bus.wr_en[p] && bus.wr_arch[p] != '0) begin
          table_next[bus.wr_arch[p]] = bus.wr_phy[p];
        end
      end
    end
  end

  // Live table register; resets to the identity map.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ARCH_NUM; i++) begin
        table_q[i] <= PHY_W'(i);
      end
    end else begin
      table_q <= table_next;
    end
  end

  // Snapshot storage; the snapshot includes this cycle's writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < CKPT_NUM; s++) begin
        for (int unsigned i = 0; i < ARCH_NUM; i++) begin
          snap_q[s][i] <= '0;
        end
      end
    end else if (snap_en) begin
      snap_q[bus.ckpt_id] <= table_next;
    end
  end
endmodule

// File: tb/tb_srat_ckpt.sv
// Scoreboard bench for srat_ckpt: directed scenarios followed by random traffic.
module tb_srat_ckpt;
  import rename_pkg::*;

  localparam int RD = 4;
  localparam int WR = 2;
  localparam int PW = PHY_W_DEF;
  localparam int N  = CKPT_NUM_DEF;

  typedef logic [ARCH_NUM-1:0][PW-1:0] tbl_t;

  typedef struct packed {
    logic [RD-1:0][ARCH_W-1:0] rd_arch;
    logic [WR-1:0]             wr_en;
    logic [WR-1:0][ARCH_W-1:0] wr_arch;
    logic [WR-1:0][PW-1:0]     wr_phy;
    logic                      req;
    logic                      rel;
    logic                      rec;
    ckpt_id_t                  rec_id;
  } stim_t;

  typedef struct packed {
    logic [RD-1:0][PW-1:0] rd_phy;
    logic                  ready;
    ckpt_id_t              id;
    logic [CKPT_W_DEF:0]   cnt;
  } exp_t;

  typedef struct packed {
    ckpt_id_t id;
    tbl_t     t;
  } ck_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sRAT_if #(.RD_PORTS(RD), .WR_PORTS(WR), .PHY_W(PW), .CKPT_NUM(N)) bus ();

  srat_ckpt #(.RD_PORTS(RD), .WR_PORTS(WR), .PHY_W(PW), .CKPT_NUM(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  tbl_t     m_tbl;
  ck_t      m_ck[$];
  ckpt_id_t m_tail;
  exp_t     exp_q[$];

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ARCH_NUM; i++) m_tbl[i] = PW'(i);
    m_ck.delete();
    m_tail = '0;
  endfunction

  // Reference: live checkpoints kept oldest-first in a queue, each holding a full copy.
  function automatic void model_step(stim_t s);
    int idx = -1;
    int sz  = m_ck.size();
    if (s.rec) begin
      for (int k = 0; k < sz; k++) if (m_ck[k].id == s.rec_id) idx = k;
    end
    if (idx >= 0) begin
      m_tbl = m_ck[idx].t;
      while (m_ck.size() > idx) void'(m_ck.pop_back());
      m_tail = s.rec_id;
    end else begin
      for (int p = 0; p < WR; p++) begin
        if (s.wr_en[p] && s.wr_arch[p] != 0) m_tbl[s.wr_arch[p]] = s.wr_phy[p];
      end
      if (s.req && sz < N) begin
        ck_t c;
        c.id = m_tail;
        c.t  = m_tbl;
        m_ck.push_back(c);
        m_tail = ckpt_id_t'((int'(m_tail) + 1) % N);
      end
      if (s.rel && sz > 0) void'(m_ck.pop_front());
    end
  endfunction

  function automatic exp_t model_expect(stim_t s);
    exp_t e;
    for (int i = 0; i < RD; i++) e.rd_phy[i] = m_tbl[s.rd_arch[i]];
    e.ready = m_ck.size() < N;
    e.id    = m_tail;
    e.cnt   = (CKPT_W_DEF+1)'(m_ck.size());
    return e;
  endfunction

  task automatic apply(stim_t s);
    bus.rd_arch       = s.rd_arch;
    bus.wr_en         = s.wr_en;
    bus.wr_arch       = s.wr_arch;
    bus.wr_phy        = s.wr_phy;
    bus.ckpt_req      = s.req;
    bus.ckpt_release  = s.rel;
    bus.recover_valid = s.rec;
    bus.recover_id    = s.rec_id;
  endtask

  task automatic cyc(stim_t s);
    @(posedge clk);
    #1;
    apply(s);
    exp_q.push_back(model_expect(s));
    model_step(s);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    apply('0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: one expected response per issued cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < RD; i++)
          chk($sformatf("rd_phy[%0d]", i), int'(bus.rd_phy[i]), int'(e.rd_phy[i]));
        chk("ckpt_ready", int'(bus.ckpt_ready), int'(e.ready));
        chk("ckpt_id", int'(bus.ckpt_id), int'(e.id));
        chk("ckpt_cnt", int'(bus.ckpt_cnt), int'(e.cnt));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    stim_t s;
    stim_t z;
    z = '0;
    apply(z);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset_cnt", int'(bus.ckpt_cnt), 0);
    chk("reset_ready", int'(bus.ckpt_ready), 1);
    chk("reset_id", int'(bus.ckpt_id), 0);

    // identity lookups after reset
    s = z;
    s.rd_arch[0] = 5'd0; s.rd_arch[1] = 5'd5; s.rd_arch[2] = 5'd31; s.rd_arch[3] = 5'd17;
    cyc(s);
    #1;
    chk("ident_0", int'(bus.rd_phy[0]), 0);
    chk("ident_5", int'(bus.rd_phy[1]), 5);
    chk("ident_31", int'(bus.rd_phy[2]), 31);
    chk("ident_17", int'(bus.rd_phy[3]), 17);

    // same-arch dual write: higher port wins
    s = z;
    s.wr_en = 2'b11; s.wr_arch[0] = 5'd3; s.wr_arch[1] = 5'd3;
    s.wr_phy[0] = 7'd40; s.wr_phy[1] = 7'd41; s.rd_arch[0] = 5'd3;
    cyc(s);
    #1;
    chk("no_bypass_x3", int'(bus.rd_phy[0]), 3);
    s = z; s.rd_arch[0] = 5'd3;
    cyc(s);
    #1;
    chk("dual_write_x3", int'(bus.rd_phy[0]), 41);

    // checkpoint then recover restores the old mapping
    s = z; s.wr_en = 2'b01; s.wr_arch[0] = 5'd3; s.wr_phy[0] = 7'd40;
    cyc(s);
    s = z; s.req = 1'b1; s.rd_arch[0] = 5'd3;
    cyc(s);
    #1;
    chk("ckpt0_id", int'(bus.ckpt_id), 0);
    s = z; s.wr_en = 2'b01; s.wr_arch[0] = 5'd3; s.wr_phy[0] = 7'd50;
    cyc(s);
    s = z; s.rec = 1'b1; s.rec_id = 2'd0; s.rd_arch[0] = 5'd3;
    s.wr_en = 2'b10; s.wr_arch[1] = 5'd9; s.wr_phy[1] = 7'd77;
    cyc(s);
    s = z; s.rd_arch[0] = 5'd3; s.rd_arch[1] = 5'd9;
    cyc(s);
    #1;
    chk("recover_x3", int'(bus.rd_phy[0]), 40);
    chk("recover_x9", int'(bus.rd_phy[1]), 9);
    chk("recover_cnt", int'(bus.ckpt_cnt), 0);

    // fill the ring, overflow request, release, wrap
    s = z; s.req = 1'b1;
    repeat (4) cyc(s);
    cyc(z);
    #1;
    chk("full_cnt", int'(bus.ckpt_cnt), 4);
    chk("full_ready", int'(bus.ckpt_ready), 0);
    s = z; s.req = 1'b1;
    cyc(s);
    cyc(z);
    #1;
    chk("overflow_cnt", int'(bus.ckpt_cnt), 4);
    s = z; s.rel = 1'b1; s.req = 1'b1;
    cyc(s);
    cyc(z);
    #1;
    chk("release_cnt", int'(bus.ckpt_cnt), 3);
    chk("wrap_id", int'(bus.ckpt_id), 0);
    s = z; s.req = 1'b1;
    cyc(s);
    cyc(z);
    #1;
    chk("wrap_cnt", int'(bus.ckpt_cnt), 4);

    // partial recover invalidates younger slots
    do_reset();
    s = z; s.req = 1'b1;
    repeat (3) cyc(s);
    s = z; s.rec = 1'b1; s.rec_id = 2'd1;
    cyc(s);
    cyc(z);
    #1;
    chk("partial_cnt", int'(bus.ckpt_cnt), 1);
    chk("partial_id", int'(bus.ckpt_id), 1);
    s = z; s.rec = 1'b1; s.rec_id = 2'd2; s.req = 1'b1;
    s.wr_en = 2'b01; s.wr_arch[0] = 5'd7; s.wr_phy[0] = 7'd99;
    cyc(s);
    s = z; s.rd_arch[0] = 5'd7;
    cyc(s);
    #1;
    chk("stale_rec_write", int'(bus.rd_phy[0]), 99);
    chk("stale_rec_cnt", int'(bus.ckpt_cnt), 2);

    // reset asserted in the middle of a recover
    s = z; s.req = 1'b1;
    cyc(s);
    @(posedge clk);
    #1;
    s = z; s.rec = 1'b1; s.rec_id = m_ck[0].id;
    s.wr_en = 2'b01; s.wr_arch[0] = 5'd5; s.wr_phy[0] = 7'd88;
    apply(s);
    #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(z);
    s = z;
    s.rd_arch[0] = 5'd0; s.rd_arch[1] = 5'd5; s.rd_arch[2] = 5'd31; s.rd_arch[3] = 5'd3;
    cyc(s);
    #1;
    chk("rst_rec_x5", int'(bus.rd_phy[1]), 5);
    chk("rst_rec_x3", int'(bus.rd_phy[3]), 3);
    chk("rst_rec_cnt", int'(bus.ckpt_cnt), 0);

    // random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < RD; i++) s.rd_arch[i] = ARCH_W'($urandom_range(0, 31));
      s.wr_en = WR'($urandom);
      for (int p = 0; p < WR; p++) begin
        s.wr_arch[p] = ($urandom_range(0, 3) == 0) ? ARCH_W'($urandom_range(0, 31))
                                                   : ARCH_W'($urandom_range(0, 6));
        s.wr_phy[p] = PW'($urandom);
      end
      s.req    = ($urandom_range(0, 9) < 4);
      s.rel    = ($urandom_range(0, 9) < 3);
      s.rec    = ($urandom_range(0, 9) == 0);
      s.rec_id = ckpt_id_t'($urandom);
      cyc(s);
    end

    @(posedge clk);
    #1;
    apply(z);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
